pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Match sequencer for FPGA Pong. Sits above the ball and paddle blocks and decides when the ball may move. It turns keyboard bytes and the ball's score pulses into a game state machine:

- idle
- serve countdown
- play
- pause
- point pause
- game over

It also keeps both players' scores and tells the ball logic when to run, hold centred, or freeze.

## Interface
Parameters:
- START_KEY, 103 – 'g'; starts a match from IDLE or OVER.
- RESTART_KEY, 98 – 'b'; aborts to IDLE from any state.
- PAUSE_KEY, 112 – 'p'; toggles PLAY/PAUSED.
- WIN_SCORE, 7 – points needed to win; legal range 1..15.
- SERVE_FRAMES, 60 – frame ticks spent in SERVE; must be ≥1.
- POINT_FRAMES, 90 – frame ticks spent in POINT; must be ≥1.

Ports:
- i_CLK  in  1  system (pixel) clock.
- i_RST_N  in  1  reset, asynchronous, active-low.
- i_frame_tick  in  1  one-cycle pulse per video frame.
- i_key_byte  in  8  current keyboard byte; held at a level.
- i_p1_scored  in  1  one-cycle pulse; player 1 earned a point.
- i_p2_scored  in  1  one-cycle pulse; player 2 earned a point.
- o_ball_run  out  1  ball may advance.
- o_ball_hold  out  1  ball forced to centre.
- o_serve_dir  out  1  0 = serve right, 1 = serve left.
- o_p1_score  out  4  player 1 score.
- o_p2_score  out  4  player 2 score.
- o_game_over  out  1  high in OVER.
- o_winner  out  1  0 = player 1, 1 = player 2; valid while o_game_over is high.
- o_state  out  3  current state encoding, for debug and display.

## Operation
Key events:
- A key event for code K fires in a cycle when i_key_byte == K and the previous cycle's byte != K.
- A held key produces exactly one event.
- The previous-byte register resets to 0.

State encoding: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, OVER=5.

Transitions:
- RESTART event in any state → IDLE. Clears scores, serve_dir, winner and timer. Highest priority.
- IDLE: START event → SERVE; timer ← SERVE_FRAMES; scores cleared.
- SERVE: each frame tick decrements timer. A tick arriving with timer == 1 → PLAY. SERVE therefore lasts exactly SERVE_FRAMES ticks.
- PLAY, scoring:
  - i_p1_scored → p1_score+1, serve_dir ← 0 (serve toward player 2).
  - i_p2_scored → p2_score+1, serve_dir ← 1 (serve toward player 1).
  - If both pulses arrive in the same cycle, only p1 is counted.
  - If the new score == WIN_SCORE → OVER, with winner set accordingly.
  - Otherwise → POINT; timer ← POINT_FRAMES.
- PLAY: PAUSE event → PAUSED. A score pulse in the same cycle takes precedence and the pause is dropped.
- PAUSED: PAUSE event → PLAY. Timer and scores are untouched.
- POINT: timer counts ticks exactly as in SERVE. On expiry → SERVE; timer ← SERVE_FRAMES.
- OVER: START event → SERVE; scores and winner cleared; serve_dir kept.
- Score pulses outside PLAY are ignored. Frame ticks outside SERVE/POINT are ignored.

Outputs by state:
- o_ball_run = 1 only in PLAY.
- o_ball_hold = 1 in IDLE, SERVE, POINT and OVER.
- In PAUSED, run = 0 and hold = 0: the ball freezes in place, not recentred.

Arithmetic:
- Scores are 4-bit and never exceed WIN_SCORE.
- Timer is wide enough for max(SERVE_FRAMES, POINT_FRAMES), computed with $clog2.

## Timing
- Reset values: state IDLE, o_ball_run 0, o_ball_hold 1, o_serve_dir 0, scores 0, o_game_over 0, o_winner 0, o_state 0.
- All outputs come from registers or are decoded only from the state register. There is no combinational path from any input to any output.
- Latency: a qualifying input in cycle n changes state and outputs in cycle n+1.
- Key event latency: the key byte changes at cycle n → state changes at n+1.
- Reset asserted mid-match returns everything to reset values immediately (asynchronously). Deassertion is synchronised externally.
- A frame tick coinciding with a RESTART event is ignored.

## Structure
- Shared package pong_pkg holds:
  - state enum/localparams: IDLE, SERVE, PLAY, PAUSED, POINT, OVER;
  - key code constants 103, 98, 112;
  - score width (4).
- One sub-module: pong_key_event.
  - Ports: i_CLK, i_RST_N, i_key_byte, parameter KEY.
  - Output: one-cycle o_event.
  - Instantiated three times (start, restart, pause).
- The FSM, timer and score registers live in pong_game_ctrl.

## Test plan
- Reset, then START byte held for 10 cycles → exactly one transition to SERVE. After 60 frame ticks, state = PLAY and o_ball_run = 1 in the following cycle.
- In PLAY, pulse i_p2_scored → p2_score = 1, serve_dir = 1, state = POINT, hold = 1. After 90 ticks → SERVE; after 60 more → PLAY.
- WIN_SCORE = 3, give player 1 three points → o_game_over = 1, o_winner = 0, p1_score = 3. Then START → scores 0, SERVE.
- Simultaneous i_p1_scored and i_p2_scored in PLAY → p1_score +1, p2_score unchanged.
- PAUSE in PLAY → PAUSED, run = 0, hold = 0; score pulses ignored. PAUSE again → PLAY with scores unchanged.
- RESTART during SERVE with timer at 30 → IDLE, scores 0. Async reset asserted in OVER → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match sequencer.
package pong_pkg;

  // Encoded values are visible on o_state, so they are pinned explicitly.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StServe  = 3'd1,
    StPlay   = 3'd2,
    StPaused = 3'd3,
    StPoint  = 3'd4,
    StOver   = 3'd5
  } state_e;

  localparam logic [7:0] KEY_START   = 8'd103;  // 'g'
  localparam logic [7:0] KEY_RESTART = 8'd98;   // 'b'
  localparam logic [7:0] KEY_PAUSE   = 8'd112;  // 'p'

  localparam int unsigned SCORE_W = 4;

endpackage

// File: rtl/pong_key_event.sv
// Turns a level-held keyboard byte into a single-cycle event on a new press of KEY.
module pong_key_event #(
  parameter logic [7:0] KEY = 8'd0
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic [7:0] i_key_byte,
  output logic       o_event
);

  logic [7:0] r_prev_byte;

  // Remember last cycle's byte so a held key fires only once.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_prev_byte <= 8'd0;
    end else begin
      r_prev_byte <= i_key_byte;
    end
  end

  assign o_event = (i_key_byte == KEY) && (r_prev_byte != KEY);

endmodule

// File: rtl/pong_game_ctrl.sv
// Match sequencer: keyboard events and score pulses drive the Pong game state machine.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter logic [7:0]  START_KEY    = KEY_START,
  parameter logic [7:0]  RESTART_KEY  = KEY_RESTART,
  parameter logic [7:0]  PAUSE_KEY    = KEY_PAUSE,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_frame_tick,
  input  logic [7:0]         i_key_byte,
  input  logic               i_p1_scored,
  input  logic               i_p2_scored,
  output logic               o_ball_run,
  output logic               o_ball_hold,
  output logic               o_serve_dir,
  output logic [SCORE_W-1:0] o_p1_score,
  output logic [SCORE_W-1:0] o_p2_score,
  output logic               o_game_over,
  output logic               o_winner,
  output logic [2:0]         o_state
);

  localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned TIMER_W    = $clog2(MAX_FRAMES + 1);

  localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_FRAMES);
  localparam logic [TIMER_W-1:0] POINT_LOAD = TIMER_W'(POINT_FRAMES);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  state_e             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [SCORE_W-1:0] r_p1_score;
  logic [SCORE_W-1:0] r_p2_score;
  logic               r_serve_dir;
  logic               r_winner;

  logic               w_start_ev;
  logic               w_restart_ev;
  logic               w_pause_ev;
  logic [SCORE_W-1:0] w_p1_inc;
  logic [SCORE_W-1:0] w_p2_inc;

  pong_key_event #(.KEY(START_KEY)) u_start_ev (
    .i_CLK      (i_CLK),
    .i_RST_N    (i_RST_N),
    .i_key_byte (i_key_byte),
    .o_event    (w_start_ev)
  );

  pong_key_event #(.KEY(RESTART_KEY)) u_restart_ev (
    .i_CLK      (i_CLK),
    .i_RST_N    (i_RST_N),
    .i_key_byte (i_key_byte),
    .o_event    (w_restart_ev)
  );

  pong_key_event #(.KEY(PAUSE_KEY)) u_pause_ev (
    .i_CLK      (i_CLK),
    .i_RST_N    (i_RST_N),
    .i_key_byte (i_key_byte),
    .o_event    (w_pause_ev)
  );

  assign w_p1_inc = r_p1_score + SCORE_ONE;
  assign w_p2_inc = r_p2_score + SCORE_ONE;

  // Game FSM with its frame timer and score registers; restart overrides everything.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state     <= StIdle;
      r_timer     <= '0;
      r_p1_score  <= '0;
      r_p2_score  <= '0;
      r_serve_dir <= 1'b0;
      r_winner    <= 1'b0;
    end else if (w_restart_ev) begin
      r_state     <= StIdle;
      r_timer     <= '0;
      r_p1_score  <= '0;
      r_p2_score  <= '0;
      r_serve_dir <= 1'b0;
      r_winner    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start_ev) begin
            r_state    <= StServe;
            r_timer    <= SERVE_LOAD;
            r_p1_score <= '0;
            r_p2_score <= '0;
          end
        end
        StServe: begin
          if (i_frame_tick) begin
            if (r_timer == TIMER_ONE) begin
              r_state <= StPlay;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer - TIMER_ONE;
            end
          end
        end
        StPlay: begin
          // p1 wins a simultaneous score; any score drops a same-cycle pause.
          if (i_p1_scored) begin
            r_p1_score  <= w_p1_inc;
            r_serve_dir <= 1'b0;
            if (w_p1_inc == WIN_VAL) begin
              r_state  <= StOver;
              r_winner <= 1'b0;
            end else begin
              r_state <= StPoint;
              r_timer <= POINT_LOAD;
            end
          end else if (i_p2_scored) begin
            r_p2_score  <= w_p2_inc;
            r_serve_dir <= 1'b1;
            if (w_p2_inc == WIN_VAL) begin
              r_state  <= StOver;
              r_winner <= 1'b1;
            end else begin
              r_state <= StPoint;
              r_timer <= POINT_LOAD;
            end
          end else if (w_pause_ev) begin
            r_state <= StPaused;
          end
        end
        StPaused: begin
          if (w_pause_ev) begin
            r_state <= StPlay;
          end
        end
        StPoint: begin
          if (i_frame_tick) begin
            if (r_timer == TIMER_ONE) begin
              r_state <= StServe;
              r_timer <= SERVE_LOAD;
            end else begin
              r_timer <= r_timer - TIMER_ONE;
            end
          end
        end
        StOver: begin
          if (w_start_ev) begin
            r_state    <= StServe;
            r_timer    <= SERVE_LOAD;
            r_p1_score <= '0;
            r_p2_score <= '0;
            r_winner   <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Ball control is decoded from the state register only, never from inputs.
  assign o_ball_run  = (r_state == StPlay);
  assign o_ball_hold = (r_state == StIdle) || (r_state == StServe) ||
                       (r_state == StPoint) || (r_state == StOver);
  assign o_game_over = (r_state == StOver);
  assign o_serve_dir = r_serve_dir;
  assign o_p1_score  = r_p1_score;
  assign o_p2_score  = r_p2_score;
  assign o_winner    = r_winner;
  assign o_state     = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed plus randomized bench for pong_game_ctrl against a rule-level match model.
module tb_pong_game_ctrl;

  localparam int unsigned SF  = 60;
  localparam int unsigned PF  = 90;
  localparam int unsigned WIN = 3;

  localparam logic [7:0] K_START   = 8'd103;
  localparam logic [7:0] K_RESTART = 8'd98;
  localparam logic [7:0] K_PAUSE   = 8'd112;
  localparam logic [7:0] K_OTHER   = 8'h41;

  // Model state names, matching the visible o_state encoding.
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSED = 3, M_POINT = 4, M_OVER = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] key_byte = 8'd0;
  logic       p1_scored = 1'b0;
  logic       p2_scored = 1'b0;
  logic       ball_run;
  logic       ball_hold;
  logic       serve_dir;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase, frames elapsed in the current countdown, scores, etc.
  int         m_state;
  int         m_frames;
  int         m_score[2];
  int         m_dir;
  int         m_win;
  logic [7:0] m_prev;

  always #5 clk = ~clk;

  pong_game_ctrl #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SF),
    .POINT_FRAMES (PF)
  ) dut (
    .i_CLK        (clk),
    .i_RST_N      (rst_n),
    .i_frame_tick (frame_tick),
    .i_key_byte   (key_byte),
    .i_p1_scored  (p1_scored),
    .i_p2_scored  (p2_scored),
    .o_ball_run   (ball_run),
    .o_ball_hold  (ball_hold),
    .o_serve_dir  (serve_dir),
    .o_p1_score   (p1_score),
    .o_p2_score   (p2_score),
    .o_game_over  (game_over),
    .o_winner     (winner),
    .o_state      (state)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_state    = M_IDLE;
    m_frames   = 0;
    m_score[0] = 0;
    m_score[1] = 0;
    m_dir      = 0;
    m_win      = 0;
  endtask

  // One clock of match rules; key events are "byte equals K now but not last cycle".
  task automatic model_step(input bit tick, input logic [7:0] key, input bit p1, input bit p2);
    bit ev_start, ev_restart, ev_pause;
    int who;
    ev_start   = (key == K_START)   && (m_prev != K_START);
    ev_restart = (key == K_RESTART) && (m_prev != K_RESTART);
    ev_pause   = (key == K_PAUSE)   && (m_prev != K_PAUSE);
    m_prev     = key;
    if (ev_restart) begin
      model_clear();
    end else if (m_state == M_IDLE || m_state == M_OVER) begin
      if (ev_start) begin
        m_state    = M_SERVE;
        m_frames   = 0;
        m_score[0] = 0;
        m_score[1] = 0;
        m_win      = 0;
      end
    end else if (m_state == M_SERVE || m_state == M_POINT) begin
      if (tick) begin
        m_frames++;
        if (m_state == M_SERVE && m_frames == SF) begin
          m_state = M_PLAY;
        end else if (m_state == M_POINT && m_frames == PF) begin
          m_state  = M_SERVE;
          m_frames = 0;
        end
      end
    end else if (m_state == M_PLAY) begin
      who = p1 ? 0 : (p2 ? 1 : -1);
      if (who >= 0) begin
        m_score[who]++;
        m_dir = who;
        if (m_score[who] == WIN) begin
          m_state = M_OVER;
          m_win   = who;
        end else begin
          m_state  = M_POINT;
          m_frames = 0;
        end
      end else if (ev_pause) begin
        m_state = M_PAUSED;
      end
    end else if (m_state == M_PAUSED) begin
      if (ev_pause) m_state = M_PLAY;
    end
  endtask

  task automatic check_all();
    bit exp_hold;
    exp_hold = (m_state == M_IDLE) || (m_state == M_SERVE) ||
               (m_state == M_POINT) || (m_state == M_OVER);
    chk("state",     8'(state),     8'(m_state));
    chk("ball_run",  8'(ball_run),  8'(m_state == M_PLAY));
    chk("ball_hold", 8'(ball_hold), 8'(exp_hold));
    chk("serve_dir", 8'(serve_dir), 8'(m_dir));
    chk("p1_score",  8'(p1_score),  8'(m_score[0]));
    chk("p2_score",  8'(p2_score),  8'(m_score[1]));
    chk("game_over", 8'(game_over), 8'(m_state == M_OVER));
    chk("winner",    8'(winner),    8'(m_win));
  endtask

  task automatic step(input bit tick, input logic [7:0] key, input bit p1, input bit p2);
    frame_tick = tick;
    key_byte   = key;
    p1_scored  = p1;
    p2_scored  = p2;
    @(posedge clk);
    model_step(tick, key, p1, p2);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] rkey;
    bit         rtick, rp1, rp2;
    int         sel;

    model_clear();
    m_prev = 8'd0;
    #12;
    check_all();
    chk("rst_hold", 8'(ball_hold), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Held START: one transition to SERVE, then a full serve countdown.
    for (int i = 0; i < 10; i++) step(1'b0, K_START, 1'b0, 1'b0);
    chk("serve_after_start", 8'(state), 8'd1);
    ticks(SF - 1);
    chk("serve_before_last", 8'(state), 8'd1);
    ticks(1);
    chk("play_run", 8'(ball_run), 8'd1);

    // Player 2 point, point pause, serve, back to play.
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("p2_point_state", 8'(state), 8'd4);
    chk("p2_point_dir", 8'(serve_dir), 8'd1);
    ticks(PF);
    chk("point_to_serve", 8'(state), 8'd1);
    ticks(SF);
    chk("serve_to_play", 8'(state), 8'd2);

    // Simultaneous pulses: only p1 counts.
    step(1'b0, 8'd0, 1'b1, 1'b1);
    chk("simul_p1", 8'(p1_score), 8'd1);
    chk("simul_p2", 8'(p2_score), 8'd1);
    ticks(PF + SF);

    // Pause freezes the ball and ignores scores.
    step(1'b0, K_PAUSE, 1'b0, 1'b0);
    chk("paused_run", 8'(ball_run), 8'd0);
    chk("paused_hold", 8'(ball_hold), 8'd0);
    step(1'b0, K_PAUSE, 1'b1, 1'b0);
    step(1'b1, 8'd0, 1'b0, 1'b1);
    step(1'b0, K_PAUSE, 1'b0, 1'b0);
    chk("unpause_state", 8'(state), 8'd2);
    chk("unpause_p1", 8'(p1_score), 8'd1);

    // Player 1 reaches the winning score.
    step(1'b0, 8'd0, 1'b1, 1'b0);
    ticks(PF + SF);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("over_flag", 8'(game_over), 8'd1);
    chk("over_winner", 8'(winner), 8'd0);
    chk("over_p1", 8'(p1_score), 8'd3);
    step(1'b0, K_START, 1'b0, 1'b0);
    chk("restart_p1_zero", 8'(p1_score), 8'd0);

    // Restart mid-serve, with a coincident frame tick.
    ticks(30);
    step(1'b1, K_RESTART, 1'b0, 1'b0);
    chk("restart_idle", 8'(state), 8'd0);
    step(1'b0, 8'd0, 1'b0, 1'b0);

    // Random play: sparse key changes, frequent ticks, occasional score pulses.
    rkey = 8'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        sel = int'($urandom_range(0, 19));
        if (sel < 6)       rkey = 8'd0;
        else if (sel < 11) rkey = K_START;
        else if (sel < 16) rkey = K_PAUSE;
        else if (sel < 19) rkey = K_OTHER;
        else               rkey = K_RESTART;
      end
      rtick = ($urandom_range(0, 3) != 0);
      rp1   = ($urandom_range(0, 24) == 0);
      rp2   = ($urandom_range(0, 24) == 0);
      step(rtick, rkey, rp1, rp2);
    end

    // Drive a fresh match to a player 2 win, then reset asynchronously in OVER.
    step(1'b0, K_RESTART, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, K_START, 1'b0, 1'b0);
    ticks(SF);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0, 1'b0, 1'b1);
      if (i < 2) ticks(PF + SF);
    end
    chk("p2_win_over", 8'(game_over), 8'd1);
    chk("p2_win_winner", 8'(winner), 8'd1);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    m_prev = 8'd0;
    #1;
    check_all();
    chk("async_over", 8'(game_over), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
